// File: rtl/layer_controller_pkg.sv
// Shared types and defaults for the fully connected layer controller.
package layer_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int unsigned N_IN_DEFAULT    = 10;
  localparam int unsigned N_OUT_DEFAULT   = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 64;

  // Index width that stays at least one bit for degenerate counts.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_timer.sv
// Clearable up-counter; expire_o is high while the count equals TIMEOUT-1.
module layer_timer
  import layer_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned TW = idx_width(TIMEOUT);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;
  logic          expire_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Expiry is registered alongside the count so it tracks cnt_q exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= (cnt_d == TW'(TIMEOUT - 1));
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/layer_controller.sv
// Time-multiplexes one neuron datapath over all N_OUT neurons of a layer
// and hands the finished layer to the next stage with a valid/ack pair.
module layer_controller
  import layer_controller_pkg::*;
#(
  parameter int unsigned N_IN    = N_IN_DEFAULT,
  parameter int unsigned N_OUT   = N_OUT_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic                            neuron_ready_i,
  input  logic                            out_ack_i,
  output logic                            neuron_start_o,
  output logic [idx_width(N_OUT)-1:0]     neuron_sel_o,
  output logic                            res_we_o,
  output logic [idx_width(N_OUT)-1:0]     res_addr_o,
  output logic                            busy_o,
  output logic                            out_valid_o,
  output logic                            err_o
);

  localparam int unsigned SEL_W = idx_width(N_OUT);

  if (TIMEOUT <= N_IN + 2) begin : g_bad_timeout
    $error("TIMEOUT must exceed N_IN+2");
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             err_q, err_d;
  logic             nstart_q, nstart_d;
  logic             we_q, we_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             expire;

  layer_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == S_START),
    .en_i     (state_q == S_WAIT),
    .expire_o (expire)
  );

  // Next state plus next-cycle Moore outputs, so the outputs leave flops.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_START;
          sel_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (neuron_ready_i) begin
          state_d = S_STORE;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_STORE: begin
        if (sel_q == SEL_W'(N_OUT - 1)) begin
          state_d = S_DONE;
        end else begin
          sel_d   = sel_q + SEL_W'(1);
          state_d = S_START;
        end
      end
      S_DONE: begin
        if (out_ack_i) begin
          state_d = S_IDLE;
          sel_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    nstart_d = (state_d == S_START);
    we_d     = (state_d == S_STORE);
    busy_d   = (state_d != S_IDLE);
    valid_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      err_q    <= 1'b0;
      nstart_q <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      nstart_q <= nstart_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign neuron_start_o = nstart_q;
  assign neuron_sel_o   = sel_q;
  assign res_we_o       = we_q;
  assign res_addr_o     = sel_q;
  assign busy_o         = busy_q;
  assign out_valid_o    = valid_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_layer_controller.sv
// Bench for layer_controller: a per-cycle expected trace is derived from
// the ready delay of each neuron and the ack latency, then compared live.
module tb_layer_controller;

  localparam int unsigned N_IN    = 10;
  localparam int unsigned N_OUT   = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned MAXC    = 512;
  localparam int          NEVER   = TIMEOUT + 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, neuron_ready_i, out_ack_i;
  logic       neuron_start_o, res_we_o, busy_o, out_valid_o, err_o;
  logic [1:0] neuron_sel_o, res_addr_o;

  layer_controller #(.N_IN(N_IN), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .neuron_ready_i (neuron_ready_i),
    .out_ack_i      (out_ack_i),
    .neuron_start_o (neuron_start_o),
    .neuron_sel_o   (neuron_sel_o),
    .res_we_o       (res_we_o),
    .res_addr_o     (res_addr_o),
    .busy_o         (busy_o),
    .out_valid_o    (out_valid_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit err_state = 1'b0;
  int first_valid;
  int n_writes;
  int last_c;
  int dly [N_OUT];

  // Expected trace; ph: 0 idle, 1 start, 2 wait, 3 store, 4 done.
  bit e_ns [MAXC];
  bit e_we [MAXC];
  bit e_busy [MAXC];
  bit e_val [MAXC];
  bit e_err [MAXC];
  int e_sel [MAXC];
  int ph [MAXC];
  bit s_rdy [MAXC];
  bit s_ack [MAXC];

  task automatic build(input int ack_wait);
    int t;
    int w;
    bit tout;
    for (int c = 0; c < MAXC; c++) begin
      e_ns[c] = 0; e_we[c] = 0; e_busy[c] = 0; e_val[c] = 0; e_err[c] = 0;
      e_sel[c] = -1; ph[c] = 0; s_rdy[c] = 0; s_ack[c] = 0;
    end
    e_err[0] = err_state;
    t = 1;
    tout = 0;
    for (int j = 0; j < N_OUT; j++) begin
      e_ns[t] = 1; e_busy[t] = 1; e_sel[t] = j; ph[t] = 1;
      w = (dly[j] <= TIMEOUT) ? dly[j] : TIMEOUT;
      for (int k = 1; k <= w; k++) begin
        e_busy[t+k] = 1; e_sel[t+k] = j; ph[t+k] = 2;
      end
      if (dly[j] <= TIMEOUT) begin
        s_rdy[t+dly[j]] = 1;
        e_we[t+dly[j]+1] = 1; e_busy[t+dly[j]+1] = 1;
        e_sel[t+dly[j]+1] = j; ph[t+dly[j]+1] = 3;
        t = t + dly[j] + 2;
      end else begin
        t = t + TIMEOUT + 1;
        tout = 1;
        break;
      end
    end
    if (tout) begin
      e_err[t] = 1; e_err[t+1] = 1;
      last_c = t + 1;
      err_state = 1;
    end else begin
      for (int k = 0; k <= ack_wait; k++) begin
        e_busy[t+k] = 1; e_val[t+k] = 1; e_sel[t+k] = N_OUT - 1; ph[t+k] = 4;
      end
      s_ack[t+ack_wait] = 1;
      e_sel[t+ack_wait+1] = 0;
      last_c = t + ack_wait + 1;
      err_state = 0;
    end
  endtask

  // Drives one pass from cycle 0 (start presented) and checks every cycle.
  task automatic run_pass(input int ack_wait, input bit spur, input int abort_at);
    logic [1:0] xs;
    build(ack_wait);
    first_valid = -1;
    n_writes = 0;
    for (int c = 0; c <= last_c; c++) begin
      start_i        = (c == 0) || (spur && ph[c] != 0 && $urandom_range(0, 2) == 0);
      neuron_ready_i = s_rdy[c] || (spur && ph[c] != 2 && $urandom_range(0, 2) == 0);
      out_ack_i      = s_ack[c] || (spur && ph[c] >= 1 && ph[c] <= 3 && $urandom_range(0, 2) == 0);
      if (c == abort_at) begin
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({neuron_start_o, res_we_o, busy_o, out_valid_o, err_o, neuron_sel_o, res_addr_o} !== 9'd0) begin
          n_bad++;
          $display("FAIL abort_outputs cycle %0d: got %b, want 0", c,
                   {neuron_start_o, res_we_o, busy_o, out_valid_o, err_o, neuron_sel_o, res_addr_o});
        end
        start_i = 0; neuron_ready_i = 0; out_ack_i = 0;
        err_state = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      if (out_valid_o === 1'b1 && first_valid < 0) first_valid = c;
      if (res_we_o === 1'b1) n_writes++;
      n_cmp++;
      if (neuron_start_o !== e_ns[c]) begin
        n_bad++; $display("FAIL neuron_start cycle %0d: got %b, want %b", c, neuron_start_o, e_ns[c]);
      end
      n_cmp++;
      if (res_we_o !== e_we[c]) begin
        n_bad++; $display("FAIL res_we cycle %0d: got %b, want %b", c, res_we_o, e_we[c]);
      end
      n_cmp++;
      if (busy_o !== e_busy[c]) begin
        n_bad++; $display("FAIL busy cycle %0d: got %b, want %b", c, busy_o, e_busy[c]);
      end
      n_cmp++;
      if (out_valid_o !== e_val[c]) begin
        n_bad++; $display("FAIL out_valid cycle %0d: got %b, want %b", c, out_valid_o, e_val[c]);
      end
      n_cmp++;
      if (err_o !== e_err[c]) begin
        n_bad++; $display("FAIL err cycle %0d: got %b, want %b", c, err_o, e_err[c]);
      end
      if (e_sel[c] >= 0) begin
        xs = 2'(e_sel[c]);
        n_cmp++;
        if (neuron_sel_o !== xs) begin
          n_bad++; $display("FAIL neuron_sel cycle %0d: got %0d, want %0d", c, neuron_sel_o, xs);
        end
        if (e_we[c]) begin
          n_cmp++;
          if (res_addr_o !== xs) begin
            n_bad++; $display("FAIL res_addr cycle %0d: got %0d, want %0d", c, res_addr_o, xs);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    start_i = 0; neuron_ready_i = 0; out_ack_i = 0;
  endtask

  task automatic set_nominal();
    for (int j = 0; j < N_OUT; j++) dly[j] = N_IN + 2;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 0; neuron_ready_i = 0; out_ack_i = 0;
    #1;
    n_cmp++;
    if ({neuron_start_o, res_we_o, busy_o, out_valid_o, err_o, neuron_sel_o, res_addr_o} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, want 0",
               {neuron_start_o, res_we_o, busy_o, out_valid_o, err_o, neuron_sel_o, res_addr_o});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    set_nominal();
    run_pass(20, 0, -1);
    n_cmp++;
    if (first_valid != int'(N_OUT * (N_IN + 4) + 1)) begin
      n_bad++; $display("FAIL first_valid_cycle: got %0d, want %0d", first_valid, N_OUT * (N_IN + 4) + 1);
    end
    n_cmp++;
    if (n_writes != int'(N_OUT)) begin
      n_bad++; $display("FAIL nominal_writes: got %0d, want %0d", n_writes, N_OUT);
    end
  endtask

  task automatic test_timeout_and_recover();
    set_nominal();
    dly[1] = NEVER;
    run_pass(0, 0, -1);
    n_cmp++;
    if (n_writes != 1) begin
      n_bad++; $display("FAIL timeout_writes: got %0d, want 1", n_writes);
    end
    set_nominal();
    run_pass(3, 0, -1);
  endtask

  task automatic test_exact_timeout();
    set_nominal();
    dly[2] = TIMEOUT;
    run_pass(1, 0, -1);
    dly[0] = TIMEOUT + 1;
    run_pass(0, 0, -1);
  endtask

  task automatic test_spurious();
    set_nominal();
    run_pass(6, 1, -1);
    n_cmp++;
    if (n_writes != int'(N_OUT)) begin
      n_bad++; $display("FAIL spurious_writes: got %0d, want %0d", n_writes, N_OUT);
    end
  endtask

  task automatic test_reset_mid_pass();
    set_nominal();
    run_pass(0, 0, 1 + 2 * (N_IN + 4) + 6);
    set_nominal();
    run_pass(0, 0, -1);
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      for (int j = 0; j < N_OUT; j++) begin
        dly[j] = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, TIMEOUT));
      end
      run_pass(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout_and_recover();
    test_exact_timeout();
    test_spurious();
    test_reset_mid_pass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
